// File: rtl/lfsr_stepper.sv
// lfsr_stepper: start/ack LFSR stepping engine (Fibonacci or Galois) advancing N+1 steps per run.
// Optional macro LFSR_WRAP_DETECT_EN adds a sticky flag set when a run revisits the seed.
module lfsr_stepper #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 1,
    parameter bit               GALOIS    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 reseed,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_in,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     lfsr_out,
    output logic                 zero_fix,
    output logic                 wrap
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st, st_nx;
    logic [WIDTH-1:0] lfsr, seed_reg, stepped, seed_fixed;
    logic [CNT_WIDTH:0] cnt;
    logic [CNT_WIDTH-1:0] n;
    logic last, accept;

    function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] s);
        if (GALOIS) return (s >> 1) ^ (s[0] ? TAPS : '0);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    assign stepped    = step_fn(lfsr);
    assign seed_fixed = (seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_in;
    // counter is one bit wider than count so the max count cannot wrap
    assign last       = (cnt == {1'b0, n});
    assign accept     = (st == IDLE) && start && !seed_load;
    assign busy       = (st != IDLE);
    assign done       = (st == DONE);

    always_comb begin
        st_nx = st;
        st_nx = (st == IDLE) ? (accept ? RUN : IDLE) :
                (st == RUN)  ? (last ? DONE : RUN) :
                               (ack ? IDLE : DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            lfsr     <= SEED;
            seed_reg <= SEED;
            lfsr_out <= '0;
            zero_fix <= 1'b0;
            cnt      <= '0;
            n        <= '0;
        end else begin
            st <= st_nx;
            if (st == IDLE && seed_load) begin
                lfsr     <= seed_fixed;
                seed_reg <= seed_fixed;
                zero_fix <= (seed_in == '0);
            end else if (accept) begin
                n   <= count;
                cnt <= '0;
                if (reseed) lfsr <= seed_reg;
            end else if (st == RUN) begin
                lfsr <= stepped;
                cnt  <= cnt + 1'b1;
                if (last) lfsr_out <= stepped;
            end
        end
    end

`ifdef LFSR_WRAP_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else if (accept) wrap <= 1'b0;
        else if (st == RUN && stepped == seed_reg) wrap <= 1'b1;
    end
`else
    assign wrap = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_stepper.sv
// tb_lfsr_stepper: randomized runs on Fibonacci and Galois instances against a sequence-level model.
module tb_lfsr_stepper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 0, reseed = 0, seed_load = 0, ack = 0;
    logic [3:0] count = '0, seed_in = '0;
    logic busy_f, done_f, zf_f, wrap_f, busy_g, done_g, zf_g, wrap_g;
    logic [3:0] out_f, out_g;
    int errors = 0, checks = 0;
    int m_st[2], m_seed[2], m_out[2], m_wrap[2], m_zf;

    always #5 clk = ~clk;

    lfsr_stepper #(.WIDTH(4), .CNT_WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(0)) dut_f (
        .clk(clk), .rst(rst), .start(start), .count(count), .reseed(reseed),
        .seed_load(seed_load), .seed_in(seed_in), .ack(ack), .busy(busy_f),
        .done(done_f), .lfsr_out(out_f), .zero_fix(zf_f), .wrap(wrap_f));

    lfsr_stepper #(.WIDTH(4), .CNT_WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1)) dut_g (
        .clk(clk), .rst(rst), .start(start), .count(count), .reseed(reseed),
        .seed_load(seed_load), .seed_in(seed_in), .ack(ack), .busy(busy_g),
        .done(done_g), .lfsr_out(out_g), .zero_fix(zf_g), .wrap(wrap_g));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // next state from the polynomial rules: parity of tapped bits (Fibonacci) or shift-and-xor (Galois)
    function automatic int nxt(input int s, input int g);
        if (g != 0) return (s >> 1) ^ ((s % 2 == 1) ? 12 : 0);
        return ((s * 2) % 16) + ($countones(s & 12) % 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int b, input int d);
        check({tag, " busy_f"}, busy_f, b);
        check({tag, " done_f"}, done_f, d);
        check({tag, " out_f"}, out_f, m_out[0]);
        check({tag, " zf_f"}, zf_f, m_zf);
        check({tag, " wrap_f"}, wrap_f, m_wrap[0]);
        check({tag, " busy_g"}, busy_g, b);
        check({tag, " done_g"}, done_g, d);
        check({tag, " out_g"}, out_g, m_out[1]);
        check({tag, " zf_g"}, zf_g, m_zf);
        check({tag, " wrap_g"}, wrap_g, m_wrap[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 1; m_seed[i] = 1; m_out[i] = 0; m_wrap[i] = 0;
        end
        m_zf = 0;
        check_all("reset", 0, 0);
        rst = 1'b0;
    endtask

    task automatic do_seed(input int v);
        seed_load = 1'b1;
        seed_in = 4'(v);
        start = 1'($urandom % 2);
        tick();
        seed_load = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = (v == 0) ? 1 : v;
            m_seed[i] = m_st[i];
        end
        m_zf = (v == 0) ? 1 : 0;
        check_all("seed", 0, 0);
    endtask

    task automatic chaos(input int on);
        if (on != 0) begin
            start = 1'($urandom % 2);
            seed_load = 1'($urandom % 2);
            ack = 1'($urandom % 2);
            seed_in = 4'($urandom);
        end
    endtask

    task automatic do_run(input int n, input int rs, input int noisy);
        int exp_out[2], exp_wrap[2];
        start = 1'b1;
        count = 4'(n);
        reseed = 1'(rs);
        ack = (noisy != 0) ? 1'($urandom % 2) : 1'b0;
        tick();
        start = 1'b0;
        ack = 1'b0;
        reseed = 1'($urandom % 2);
        count = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (rs != 0) m_st[i] = m_seed[i];
            m_wrap[i] = 0;
            exp_wrap[i] = 0;
            for (int k = 0; k <= n; k++) begin
                m_st[i] = nxt(m_st[i], i);
`ifdef LFSR_WRAP_DETECT_EN
                if (m_st[i] == m_seed[i]) exp_wrap[i] = 1;
`endif
            end
            exp_out[i] = m_st[i];
        end
        check_all("run_start", 1, 0);
        for (int k = 1; k <= n; k++) begin
            chaos(noisy);
            tick();
            check("running busy_f", busy_f, 1);
            check("running done_f", done_f, 0);
            check("running out_f", out_f, m_out[0]);
            check("running done_g", done_g, 0);
            check("running out_g", out_g, m_out[1]);
        end
        chaos(noisy);
        tick();
        start = 1'b0; seed_load = 1'b0; ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = exp_out[i];
            m_wrap[i] = exp_wrap[i];
        end
        check_all("done", 1, 1);
        repeat ($urandom_range(0, 3)) begin
            start = 1'($urandom % 2);
            tick();
            start = 1'b0;
            check_all("hold", 1, 1);
        end
        ack = 1'b1;
        start = 1'($urandom % 2);
        tick();
        ack = 1'b0;
        start = 1'b0;
        check_all("ack", 0, 0);
    endtask

    initial begin
        tick();
        do_reset();
        do_run(2, 0, 0);
        check("tp1 out", out_f, 4'b1001);
        do_run(0, 0, 0);
        check("tp2 continue", out_f, 4'b0011);
        do_run(0, 1, 0);
        check("tp2 reseed", out_f, 4'b0010);
        do_seed(0);
        check("tp3 zero_fix set", zf_f, 1);
        do_seed(6);
        check("tp3 zero_fix clear", zf_f, 0);
        do_run(0, 0, 0);
        check("tp3 out", out_f, 4'b1101);
        do_seed(1);
        do_run(15, 0, 0);
        check("tp4 out", out_f, 4'b0010);
`ifdef LFSR_WRAP_DETECT_EN
        check("tp4 wrap", wrap_f, 1);
`else
        check("tp4 wrap", wrap_f, 0);
`endif
        do_seed(1);
        do_run(0, 0, 0);
        check("tp6 galois", out_g, 4'b1100);
        start = 1'b1; count = 4'd10; reseed = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        do_reset();
        do_run(2, 0, 1);
        check("tp5 out", out_f, 4'b1001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_all("idle_ack", 0, 0);
        repeat (40) begin
            if ($urandom % 4 == 0) do_seed(int'($urandom % 16));
            else do_run(int'($urandom % 16), int'($urandom % 2), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
